// File: rtl/ntsc_pat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntsc_pat_pkg
//  Description : Shared types and helpers for the NTSC composite pattern
//                generator: pattern modes, hue-sign table, width limits.
//  Revision    : 1.0  initial release
// ============================================================================
package ntsc_pat_pkg;

  // Pattern selected once per frame
  typedef enum logic [1:0] {
    MODE_BAR   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_HATCH = 2'd2,
    MODE_FLAT  = 2'd3
  } pat_mode_e;

  // Legal composite DAC widths
  localparam int DAC_W_MIN = 8;
  localparam int DAC_W_MAX = 12;

  // Subcarrier sample and chroma widths (chroma holds the sum of two samples)
  localparam int SAMPLE_W = 4;
  localparam int CHROMA_W = 6;

  // Contribution of one subcarrier component to a hue
  typedef enum logic [1:0] {
    SGN_ZERO = 2'd0,
    SGN_POS  = 2'd1,
    SGN_NEG  = 2'd2
  } sgn_e;

  typedef struct packed {
    sgn_e k_cos;
    sgn_e k_sin;
  } hue_sign_t;

  // Eight hues spaced around the colour circle, starting at +cos
  function automatic hue_sign_t hue_sign(input logic [2:0] hue);
    hue_sign_t s;
    case (hue)
      3'd0:    s = '{k_cos: SGN_POS,  k_sin: SGN_ZERO};
      3'd1:    s = '{k_cos: SGN_POS,  k_sin: SGN_NEG};
      3'd2:    s = '{k_cos: SGN_ZERO, k_sin: SGN_NEG};
      3'd3:    s = '{k_cos: SGN_NEG,  k_sin: SGN_NEG};
      3'd4:    s = '{k_cos: SGN_NEG,  k_sin: SGN_ZERO};
      3'd5:    s = '{k_cos: SGN_NEG,  k_sin: SGN_POS};
      3'd6:    s = '{k_cos: SGN_ZERO, k_sin: SGN_POS};
      default: s = '{k_cos: SGN_POS,  k_sin: SGN_POS};
    endcase
    return s;
  endfunction

  // Sign-extend a subcarrier sample to chroma width, then apply a sign
  function automatic logic signed [CHROMA_W-1:0] signed_term(
    input sgn_e                        k,
    input logic signed [SAMPLE_W-1:0]  s
  );
    logic signed [CHROMA_W-1:0] ext;
    ext = CHROMA_W'(s);
    case (k)
      SGN_POS: return ext;
      SGN_NEG: return -ext;
      default: return '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntsc_pat_chroma.sv
`default_nettype none
// ============================================================================
//  Module      : ntsc_pat_chroma
//  Description : Combinational hue-to-chroma mapping. Combines the sin/cos
//                subcarrier samples according to the hue index into a signed
//                chroma value.
//  Revision    : 1.0  initial release
// ============================================================================
module ntsc_pat_chroma
  import ntsc_pat_pkg::*;
(
  input  logic        [2:0]          i_hue,
  input  logic signed [SAMPLE_W-1:0] i_sin,
  input  logic signed [SAMPLE_W-1:0] i_cos,
  output logic signed [CHROMA_W-1:0] o_chroma
);

  hue_sign_t w_sgn;

  // Look up the component signs for this hue and sum the signed terms
  always_comb begin
    w_sgn    = hue_sign(i_hue);
    o_chroma = signed_term(w_sgn.k_cos, i_cos) + signed_term(w_sgn.k_sin, i_sin);
  end

endmodule
`default_nettype wire

// File: rtl/ntsc_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ntsc_pattern_gen
//  Description : NTSC composite test-pattern generator (bars, ramp, crosshatch,
//                flat field) with pedestal, chroma scaling and output clamp.
//                Two-stage pipeline advanced by CK_EE_i.
//                Build option NTSC_PAT_CHROMA_EN: when defined, chroma and
//                colour burst are generated; otherwise output is monochrome.
//  Revision    : 1.0  initial release
// ============================================================================
module ntsc_pattern_gen
  import ntsc_pat_pkg::*;
#(
  parameter int P_DAC_W     = 10,
  parameter int P_PEDE      = 205,
  parameter int P_CHROMA_SH = 4,
  parameter int P_BAR_Y     = 100,
  parameter int P_WHITE     = 510,
  parameter int P_CLAMP_LO  = 16
) (
  input  logic                       CK_i,
  input  logic                       RST_i,
  input  logic                       CK_EE_i,
  input  logic        [9:0]          HCTRs_i,
  input  logic        [8:0]          VCTRs_i,
  input  logic                       XBLK_i,
  input  logic                       XSYNC_i,
  input  logic                       BURST_i,
  input  logic signed [SAMPLE_W-1:0] sin_s_i,
  input  logic signed [SAMPLE_W-1:0] cos_s_i,
  input  logic        [1:0]          MODE_i,
  input  logic        [7:0]          LEVEL_i,
  input  logic                       FREEZE_i,
  output logic        [P_DAC_W-1:0]  VIDEOs_o,
  output logic        [1:0]          MODE_o,
  output logic        [7:0]          FCTRs_o,
  output logic                       FRAME_o
);

  // Signed working width: at least DAC width + 3, widened so that the largest
  // pedestal + luma + shifted chroma never wraps before clamping.
  localparam int SUM_W = (P_DAC_W + 3 < 14) ? 14 : (P_DAC_W + 3);

  localparam logic signed [SUM_W-1:0] C_ZERO  = '0;
  localparam logic signed [SUM_W-1:0] C_PEDE  = SUM_W'(P_PEDE);
  localparam logic signed [SUM_W-1:0] C_BAR_Y = SUM_W'(P_BAR_Y);
  localparam logic signed [SUM_W-1:0] C_WHITE = SUM_W'(P_WHITE);
  localparam logic signed [SUM_W-1:0] C_LO    = SUM_W'(P_CLAMP_LO);
  localparam logic signed [SUM_W-1:0] C_HI    = SUM_W'((1 << P_DAC_W) - 1);

  // Saturate a signed working value into the DAC range [lo, 2^P_DAC_W-1]
  function automatic logic [P_DAC_W-1:0] sat(
    input logic signed [SUM_W-1:0] x,
    input logic signed [SUM_W-1:0] lo
  );
    if (x < lo)        return P_DAC_W'(lo);
    else if (x > C_HI) return P_DAC_W'(C_HI);
    else               return x[P_DAC_W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Frame-level state
  // --------------------------------------------------------------------------
  logic       frame_start;
  pat_mode_e  mode_q,  mode_d;
  logic [7:0] level_q, level_d;
  logic [7:0] fctr_q,  fctr_d;

  assign frame_start = CK_EE_i && (HCTRs_i == 10'd0) && (VCTRs_i == 9'd0);

  // Capture mode/level and step the frame counter at frame start; the _d
  // values are also what the frame-start pixel itself is rendered with.
  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    fctr_d  = fctr_q;
    if (frame_start) begin
      mode_d  = pat_mode_e'(MODE_i);
      level_d = LEVEL_i;
      if (!FREEZE_i) fctr_d = fctr_q + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: luma, chroma and control capture
  // --------------------------------------------------------------------------
  logic [7:0]              ramp_byte;
  logic                    hatch_line;
  logic signed [SUM_W-1:0] y_d, y_q;
  logic                    xsync_q, xblk_q, burst_q;

  // Luma for the pattern in effect
  always_comb begin
    ramp_byte  = 8'(HCTRs_i[9:1] + VCTRs_i + {1'b0, fctr_d});
    hatch_line = (HCTRs_i[4:0] == 5'd0) || (VCTRs_i[3:0] == 4'd0);
    y_d        = C_ZERO;
    case (mode_d)
      MODE_BAR:   y_d = C_BAR_Y;
      MODE_RAMP:  y_d = {{(SUM_W-9){1'b0}}, ramp_byte, 1'b0};
      MODE_HATCH: y_d = hatch_line ? C_WHITE : C_ZERO;
      MODE_FLAT:  y_d = {{(SUM_W-9){1'b0}}, level_d, 1'b0};
      default:    y_d = C_ZERO;
    endcase
  end

  logic signed [SUM_W-1:0] active_sum;
  logic signed [SUM_W-1:0] burst_sum;

`ifdef NTSC_PAT_CHROMA_EN
  logic signed [CHROMA_W-1:0] hue_c;
  logic signed [CHROMA_W-1:0] c_d, c_q;
  logic signed [CHROMA_W-1:0] bval_d, bval_q;
  logic signed [SUM_W-1:0]    c_ext, b_ext;

  ntsc_pat_chroma u_chroma (
    .i_hue    (HCTRs_i[8:6]),
    .i_sin    (sin_s_i),
    .i_cos    (cos_s_i),
    .o_chroma (hue_c)
  );

  // Only bars and ramp carry colour; burst is always the -cos phase
  always_comb begin
    c_d    = ((mode_d == MODE_BAR) || (mode_d == MODE_RAMP)) ? hue_c : '0;
    bval_d = signed_term(SGN_NEG, cos_s_i);
  end

  // Stage-1 chroma and burst registers
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      c_q    <= '0;
      bval_q <= '0;
    end else if (CK_EE_i) begin
      c_q    <= c_d;
      bval_q <= bval_d;
    end
  end

  // Pedestal + luma + scaled chroma, and pedestal + scaled burst
  always_comb begin
    c_ext      = SUM_W'(c_q);
    b_ext      = SUM_W'(bval_q);
    active_sum = C_PEDE + y_q + (c_ext <<< P_CHROMA_SH);
    burst_sum  = C_PEDE + (b_ext <<< P_CHROMA_SH);
  end
`else
  // Monochrome build: subcarrier inputs are ignored, burst sits at pedestal
  logic unused_subcarrier;
  assign unused_subcarrier = ^{sin_s_i, cos_s_i};

  // Pedestal + luma only
  always_comb begin
    active_sum = C_PEDE + y_q;
    burst_sum  = C_PEDE;
  end
`endif

  // --------------------------------------------------------------------------
  // Stage 2: output select and clamp
  // --------------------------------------------------------------------------
  logic [P_DAC_W-1:0] video_d, video_q;

  // Sync beats burst beats blanking beats active video
  always_comb begin
    video_d = video_q;
    if (!xsync_q)      video_d = '0;
    else if (burst_q)  video_d = sat(burst_sum, C_ZERO);
    else if (!xblk_q)  video_d = P_DAC_W'(P_PEDE);
    else               video_d = sat(active_sum, C_LO);
  end

  // Frame state, stage-1 and stage-2 registers; reset wins over the enable
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      mode_q  <= MODE_BAR;
      level_q <= '0;
      fctr_q  <= '0;
      y_q     <= C_ZERO;
      xsync_q <= 1'b1;
      xblk_q  <= 1'b0;
      burst_q <= 1'b0;
      video_q <= P_DAC_W'(P_PEDE);
    end else if (CK_EE_i) begin
      mode_q  <= mode_d;
      level_q <= level_d;
      fctr_q  <= fctr_d;
      y_q     <= y_d;
      xsync_q <= XSYNC_i;
      xblk_q  <= XBLK_i;
      burst_q <= BURST_i;
      video_q <= video_d;
    end
  end

  assign VIDEOs_o = video_q;
  assign MODE_o   = mode_q;
  assign FCTRs_o  = fctr_q;
  assign FRAME_o  = frame_start && !RST_i;

endmodule
`default_nettype wire

// File: tb/tb_ntsc_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntsc_pattern_gen
//  Description : Self-checking bench for ntsc_pattern_gen. Two instances
//                (chroma shift 4 and 5) share stimulus; a behavioural model
//                predicts every output sample.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ntsc_pattern_gen;

  localparam int DAC_W    = 10;
  localparam int PEDE     = 205;
  localparam int BAR_Y    = 100;
  localparam int WHITE    = 510;
  localparam int CLAMP_LO = 16;
  localparam int DAC_MAX  = (1 << DAC_W) - 1;
`ifdef NTSC_PAT_CHROMA_EN
  localparam bit CHROMA_EN = 1'b1;
`else
  localparam bit CHROMA_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, ce;
  logic [9:0]        hctr;
  logic [8:0]        vctr;
  logic              xblk, xsync, burst;
  logic [3:0]        sin_s, cos_s;
  logic [1:0]        mode_in;
  logic [7:0]        level;
  logic              freeze;
  logic [DAC_W-1:0]  video4, video5;
  logic [1:0]        mode4, mode5;
  logic [7:0]        fctr4, fctr5;
  logic              frame4, frame5;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_mode, m_level, m_fctr;
  int s1_4, s1_5, exp4, exp5;

  always #5 clk = ~clk;

  ntsc_pattern_gen #(.P_DAC_W(DAC_W), .P_PEDE(PEDE), .P_CHROMA_SH(4), .P_BAR_Y(BAR_Y),
                     .P_WHITE(WHITE), .P_CLAMP_LO(CLAMP_LO)) dut4 (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ce), .HCTRs_i(hctr), .VCTRs_i(vctr),
    .XBLK_i(xblk), .XSYNC_i(xsync), .BURST_i(burst), .sin_s_i(sin_s), .cos_s_i(cos_s),
    .MODE_i(mode_in), .LEVEL_i(level), .FREEZE_i(freeze),
    .VIDEOs_o(video4), .MODE_o(mode4), .FCTRs_o(fctr4), .FRAME_o(frame4));

  ntsc_pattern_gen #(.P_DAC_W(DAC_W), .P_PEDE(PEDE), .P_CHROMA_SH(5), .P_BAR_Y(BAR_Y),
                     .P_WHITE(WHITE), .P_CLAMP_LO(CLAMP_LO)) dut5 (
    .CK_i(clk), .RST_i(rst), .CK_EE_i(ce), .HCTRs_i(hctr), .VCTRs_i(vctr),
    .XBLK_i(xblk), .XSYNC_i(xsync), .BURST_i(burst), .sin_s_i(sin_s), .cos_s_i(cos_s),
    .MODE_i(mode_in), .LEVEL_i(level), .FREEZE_i(freeze),
    .VIDEOs_o(video5), .MODE_o(mode5), .FCTRs_o(fctr5), .FRAME_o(frame5));

  task automatic check_eq(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int chroma_of(input int hue, input int s, input int c);
    case (hue)
      0: return c;
      1: return c - s;
      2: return -s;
      3: return -c - s;
      4: return -c;
      5: return -c + s;
      6: return s;
      default: return c + s;
    endcase
  endfunction

  // Composite value for the current inputs under the model's frame state
  function automatic int model_sample(input int sh);
    int s, c, y, ch;
    s = int'($signed(sin_s));
    c = int'($signed(cos_s));
    if (!xsync) return 0;
    if (burst)  return CHROMA_EN ? clampi(PEDE - c * (1 << sh), 0, DAC_MAX) : PEDE;
    if (!xblk)  return PEDE;
    case (m_mode)
      0: y = BAR_Y;
      1: y = 2 * ((int'(hctr) / 2 + int'(vctr) + m_fctr) % 256);
      2: y = ((hctr % 32 == 0) || (vctr % 16 == 0)) ? WHITE : 0;
      default: y = 2 * m_level;
    endcase
    ch = (CHROMA_EN && m_mode < 2) ? chroma_of((int'(hctr) / 64) % 8, s, c) : 0;
    return clampi(PEDE + y + ch * (1 << sh), CLAMP_LO, DAC_MAX);
  endfunction

  // One clock: inputs already driven; check frame pulse, advance model, check outputs
  task automatic run_cycle();
    bit fs;
    #1;
    fs = ce && (hctr == 0) && (vctr == 0) && !rst;
    check_eq("frame_pulse", int'(frame4), int'(fs));
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_level = 0; m_fctr = 0;
      s1_4 = PEDE; s1_5 = PEDE; exp4 = PEDE; exp5 = PEDE;
    end else if (ce) begin
      if (fs) begin
        m_mode  = int'(mode_in);
        m_level = int'(level);
        if (!freeze) m_fctr = (m_fctr + 1) % 256;
      end
      exp4 = s1_4; s1_4 = model_sample(4);
      exp5 = s1_5; s1_5 = model_sample(5);
    end
    #1;
    check_eq("video_sh4", int'(video4), exp4);
    check_eq("video_sh5", int'(video5), exp5);
    check_eq("mode_o",    int'(mode4),  m_mode);
    check_eq("fctr_o",    int'(fctr4),  m_fctr);
  endtask

  task automatic frame_start_cycle(input bit frz);
    hctr = 10'd0; vctr = 9'd0; freeze = frz;
    run_cycle();
    hctr = 10'd1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; hctr = 10'd5; vctr = 9'd5;
    xblk = 1'b0; xsync = 1'b1; burst = 1'b0;
    sin_s = 4'd0; cos_s = 4'd0; mode_in = 2'd0; level = 8'd0; freeze = 1'b0;
    m_mode = 0; m_level = 0; m_fctr = 0; s1_4 = PEDE; s1_5 = PEDE; exp4 = PEDE; exp5 = PEDE;

    // reset
    repeat (5) run_cycle();
    check_eq("rst_video", int'(video4), 205);
    check_eq("rst_mode",  int'(mode4),  0);
    check_eq("rst_fctr",  int'(fctr4),  0);
    rst = 1'b0;
    repeat (2) run_cycle();
    check_eq("post_rst_blank", int'(video4), 205);

    // colour bars, hue 0, cos=7
    xblk = 1'b1; hctr = 10'd10; vctr = 9'd20; cos_s = 4'd7; sin_s = 4'd0;
    repeat (2) run_cycle();
    check_eq("bar_hue0", int'(video4), CHROMA_EN ? 417 : 305);

    // mode request mid-frame is deferred to the next frame start
    mode_in = 2'd3; level = 8'd255;
    repeat (3) run_cycle();
    check_eq("mode_deferred", int'(video4), CHROMA_EN ? 417 : 305);
    frame_start_cycle(1'b0);
    run_cycle();
    check_eq("flat_first_px", int'(video4), 715);
    check_eq("flat_mode", int'(mode4), 3);

    // sync during active video, with enable stalls
    xsync = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce = i[0];
      run_cycle();
    end
    ce = 1'b1;
    run_cycle();
    check_eq("sync_level", int'(video4), 0);

    // burst with cos=7, with a stall in the middle
    xsync = 1'b1; burst = 1'b1; cos_s = 4'd7;
    run_cycle();
    ce = 1'b0;
    repeat (3) run_cycle();
    ce = 1'b1;
    run_cycle();
    check_eq("burst_level", int'(video4), CHROMA_EN ? 93 : 205);
    burst = 1'b0;

    // frame counter wrap and freeze
    for (int i = 0; i < 300 && m_fctr != 255; i++) frame_start_cycle(1'b0);
    check_eq("fctr_at_255", int'(fctr4), 255);
    frame_start_cycle(1'b1);
    check_eq("fctr_frozen", int'(fctr4), 255);
    frame_start_cycle(1'b0);
    check_eq("fctr_wrap", int'(fctr4), 0);

    // clamp on the shift-5 instance in ramp mode
    mode_in = 2'd1;
    frame_start_cycle(1'b0);
    cos_s = 4'd7; sin_s = 4'd7;
    hctr = 10'd450; vctr = 9'((30 - m_fctr) & 255);
    repeat (2) run_cycle();
    check_eq("clamp_high", int'(video5), CHROMA_EN ? 1023 : 715);
    hctr = 10'd200; vctr = 9'((256 - 100 - m_fctr) & 255);
    repeat (2) run_cycle();
    check_eq("clamp_low", int'(video5), CHROMA_EN ? 16 : 205);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      ce  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        hctr = 10'd0; vctr = 9'd0;
      end else begin
        hctr = 10'($urandom_range(0, 1023));
        vctr = 9'($urandom_range(0, 511));
      end
      xsync   = ($urandom_range(0, 7) != 0);
      burst   = ($urandom_range(0, 7) == 0);
      xblk    = ($urandom_range(0, 5) != 0);
      sin_s   = 4'($urandom);
      cos_s   = 4'($urandom);
      mode_in = 2'($urandom);
      level   = 8'($urandom);
      freeze  = ($urandom_range(0, 3) == 0);
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
